// File: rtl/team_06_audio_pkg.sv
// Shared widths and sample types for the team_06 audio output path.
package team_06_audio_pkg;
  localparam int AUDIO_IN_W  = 8;
  localparam int AUDIO_OUT_W = 16;
  localparam int VOL_W       = 4;
  localparam logic [AUDIO_OUT_W-1:0] AUDIO_MAX = 16'hFFFF;
  // Width of the unsaturated intermediate: input shifted by the largest gain code.
  localparam int SHIFT_W = AUDIO_IN_W + (2**VOL_W) - 1;

  typedef logic [AUDIO_IN_W-1:0]  sample_in_t;
  typedef logic [AUDIO_OUT_W-1:0] sample_out_t;
  typedef logic [VOL_W-1:0]       vol_t;
endpackage

// File: rtl/team_06_sat_shift.sv
// Combinational power-of-two gain with saturation to the 16-bit output range.
module team_06_sat_shift
  import team_06_audio_pkg::*;
(
  input  sample_in_t  sample,
  input  vol_t        shift,
  output sample_out_t result
);
  logic [SHIFT_W-1:0] wide;

  always_comb begin
    wide   = {{(SHIFT_W-AUDIO_IN_W){1'b0}}, sample} << shift;
    result = (|wide[SHIFT_W-1:AUDIO_OUT_W]) ? AUDIO_MAX : wide[AUDIO_OUT_W-1:0];
  end
endmodule

// File: rtl/team_06_volume_shifter.sv
// Registered digital volume stage: saturated power-of-two gain or zero-extended bypass.
// Optional gain ramp (anti-zipper) enabled by defining TEAM_06_VOLUME_RAMP_EN.
module team_06_volume_shifter
  import team_06_audio_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  audio_in,
  input  logic [3:0]  volume,
  input  logic        enable_volume,
  output logic [15:0] audio_out
);
  vol_t        vol_eff;
  sample_out_t gained;
  sample_out_t next_out;

`ifdef TEAM_06_VOLUME_RAMP_EN
  vol_t vol_ramp;

  // Gain uses the pre-edge ramp value; the ramp frozen while bypassed.
  always_ff @(posedge clk) begin
    if (rst) begin
      vol_ramp <= '0;
    end else if (enable_volume) begin
      if (vol_ramp < volume)
        vol_ramp <= vol_ramp + vol_t'(1);
      else if (vol_ramp > volume)
        vol_ramp <= vol_ramp - vol_t'(1);
    end
  end

  assign vol_eff = vol_ramp;
`else
  assign vol_eff = volume;
`endif

  team_06_sat_shift u_sat_shift (
    .sample (audio_in),
    .shift  (vol_eff),
    .result (gained)
  );

  always_comb begin
    next_out = {{(AUDIO_OUT_W-AUDIO_IN_W){1'b0}}, audio_in};
    if (enable_volume)
      next_out = gained;
  end

  always_ff @(posedge clk) begin
    if (rst)
      audio_out <= '0;
    else
      audio_out <= next_out;
  end
endmodule

// File: tb/tb_team_06_volume_shifter.sv
// Self-checking bench for team_06_volume_shifter: vector table, random vectors and reset/ramp sequences.
module tb_team_06_volume_shifter;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  audio_in;
  logic [3:0]  volume;
  logic        enable_volume;
  logic [15:0] audio_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] exp;
    string       name;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [7:0]  a;
    logic [3:0]  v;
    logic        en;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[13];

  logic [15:0] prev_exp;
  logic        prev_valid = 1'b0;

  team_06_volume_shifter dut (
    .clk           (clk),
    .rst           (rst),
    .audio_in      (audio_in),
    .volume        (volume),
    .enable_volume (enable_volume),
    .audio_out     (audio_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [7:0] a, input logic [3:0] v, input logic en);
    longint p;
    if (!en) return {8'h00, a};
    p = longint'(a) * (longint'(1) << v);
    if (p > 65535) return 16'hFFFF;
    return 16'(p);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one edge worth of inputs; expected result is queued and checked after the edge.
  task automatic apply(input logic r, input logic [7:0] a, input logic [3:0] v,
                       input logic en, input logic [15:0] exp, input string name);
    sb_t item;
    @(negedge clk);
    rst = r; audio_in = a; volume = v; enable_volume = en;
    item.exp = exp; item.name = name;
    sb.push_back(item);
    #1;
    if (prev_valid) check({name, "_hold"}, audio_out, prev_exp);
    @(posedge clk);
    #1;
    item = sb.pop_front();
    check(item.name, audio_out, item.exp);
    prev_exp   = item.exp;
    prev_valid = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{8'd64,  4'd6,  1'b0, 16'h0040};
    tbl[1]  = '{8'd64,  4'd6,  1'b1, 16'h1000};
    tbl[2]  = '{8'd255, 4'd8,  1'b1, 16'hFF00};
    tbl[3]  = '{8'd255, 4'd15, 1'b1, 16'hFFFF};
    tbl[4]  = '{8'd128, 4'd9,  1'b1, 16'hFFFF};
    tbl[5]  = '{8'd128, 4'd8,  1'b1, 16'h8000};
    tbl[6]  = '{8'd173, 4'd0,  1'b1, 16'h00AD};
    tbl[7]  = '{8'd0,   4'd15, 1'b1, 16'h0000};
    tbl[8]  = '{8'd255, 4'd15, 1'b0, 16'h00FF};
    tbl[9]  = '{8'd255, 4'd7,  1'b1, 16'h7F80};
    tbl[10] = '{8'd1,   4'd15, 1'b1, 16'h8000};
    tbl[11] = '{8'd127, 4'd9,  1'b1, 16'hFE00};
    tbl[12] = '{8'd0,   4'd3,  1'b0, 16'h0000};

    rst = 1'b1; audio_in = 8'hA5; volume = 4'd3; enable_volume = 1'b1;
    apply(1'b1, 8'hA5, 4'd3, 1'b1, 16'h0000, "reset");

`ifdef TEAM_06_VOLUME_RAMP_EN
    apply(1'b0, 8'd1, 4'd4, 1'b1, 16'd1,  "ramp0");
    apply(1'b0, 8'd1, 4'd4, 1'b1, 16'd2,  "ramp1");
    apply(1'b0, 8'd1, 4'd4, 1'b1, 16'd4,  "ramp2");
    apply(1'b0, 8'd1, 4'd4, 1'b1, 16'd8,  "ramp3");
    apply(1'b0, 8'd1, 4'd4, 1'b1, 16'd16, "ramp4");
    apply(1'b0, 8'd1, 4'd4, 1'b1, 16'd16, "ramp5");
    apply(1'b0, 8'd1, 4'd0, 1'b0, 16'd1,  "ramp_bypass");
    apply(1'b0, 8'd1, 4'd4, 1'b1, 16'd16, "ramp_held");
    apply(1'b0, 8'd1, 4'd2, 1'b1, 16'd16, "ramp_down0");
    apply(1'b0, 8'd1, 4'd2, 1'b1, 16'd8,  "ramp_down1");
    apply(1'b0, 8'd1, 4'd2, 1'b1, 16'd4,  "ramp_down2");
    apply(1'b1, 8'd1, 4'd2, 1'b1, 16'd0,  "ramp_rst");
    apply(1'b0, 8'd1, 4'd2, 1'b1, 16'd1,  "ramp_after_rst");
`else
    for (int i = 0; i < 13; i++)
      apply(1'b0, tbl[i].a, tbl[i].v, tbl[i].en, tbl[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 24; i++) begin
      logic [7:0] a;
      logic [3:0] v;
      logic       en;
      a  = 8'($urandom_range(0, 255));
      v  = 4'($urandom_range(0, 15));
      en = 1'($urandom_range(0, 1));
      apply(1'b0, a, v, en, model(a, v, en), $sformatf("rand%0d", i));
    end

    apply(1'b0, 8'd255, 4'd15, 1'b1, 16'hFFFF, "stream0");
    apply(1'b0, 8'd255, 4'd15, 1'b1, 16'hFFFF, "stream1");
    apply(1'b1, 8'd255, 4'd15, 1'b1, 16'h0000, "midrst");
    apply(1'b0, 8'd255, 4'd15, 1'b1, 16'hFFFF, "post_rst");
    apply(1'b0, 8'd200, 4'd2,  1'b0, 16'h00C8, "to_bypass");
`endif

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end
endmodule
